// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// reservation_station_if: dispatch, CDB and issue bundle of a reservation station
// Revision: 1.0
// ============================================================================
interface reservation_station_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int OP_W   = 4
);
  logic              res_valid_o;
  logic              res_load_i;
  logic [OP_W-1:0]   op_i;
  logic [TAG_W-1:0]  dest_tag_i;
  logic              src1_rdy_i;
  logic              src2_rdy_i;
  logic [TAG_W-1:0]  src1_tag_i;
  logic [TAG_W-1:0]  src2_tag_i;
  logic [DATA_W-1:0] src1_val_i;
  logic [DATA_W-1:0] src2_val_i;
  logic              cdb_valid_i;
  logic [TAG_W-1:0]  cdb_tag_i;
  logic [DATA_W-1:0] cdb_data_i;
  logic              issue_valid_o;
  logic              fu_ready_i;
  logic [OP_W-1:0]   issue_op_o;
  logic [TAG_W-1:0]  issue_dest_o;
  logic [DATA_W-1:0] issue_a_o;
  logic [DATA_W-1:0] issue_b_o;

  modport master (
    input  res_valid_o, issue_valid_o, issue_op_o, issue_dest_o, issue_a_o, issue_b_o,
    output res_load_i, op_i, dest_tag_i, src1_rdy_i, src2_rdy_i, src1_tag_i, src2_tag_i,
           src1_val_i, src2_val_i, cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i
  );

  modport slave (
    output res_valid_o, issue_valid_o, issue_op_o, issue_dest_o, issue_a_o, issue_b_o,
    input  res_load_i, op_i, dest_tag_i, src1_rdy_i, src2_rdy_i, src1_tag_i, src2_tag_i,
           src1_val_i, src2_val_i, cdb_valid_i, cdb_tag_i, cdb_data_i, fu_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// reservation_station: holds dispatched ops until both operands arrive, then issues
// Revision: 1.0
// ============================================================================
module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int OP_W   = 4
) (
  input  wire logic             clk_i,
  input  wire logic             reset_n_i,
  input  wire logic             flush_i,
  reservation_station_if.slave  rs_if
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [TAG_W-1:0]  tag1_q [DEPTH];
  logic [TAG_W-1:0]  tag1_d [DEPTH];
  logic [TAG_W-1:0]  tag2_q [DEPTH];
  logic [TAG_W-1:0]  tag2_d [DEPTH];
  logic [DATA_W-1:0] val1_q [DEPTH];
  logic [DATA_W-1:0] val1_d [DEPTH];
  logic [DATA_W-1:0] val2_q [DEPTH];
  logic [DATA_W-1:0] val2_d [DEPTH];

  logic [DEPTH-1:0]  cand;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_free;
  logic              any_cand;
  logic              load_fire;
  logic              issue_fire;

  // Candidates come from registered readiness only, so a CDB wakeup never issues in the same cycle.
  assign cand       = busy_q & rdy1_q & rdy2_q;
  assign any_free   = ~(&busy_q);
  assign any_cand   = |cand;
  assign load_fire  = rs_if.res_load_i & any_free;
  assign issue_fire = any_cand & rs_if.fu_ready_i;

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (cand[i])    sel_idx  = IDX_W'(i);
    end
  end

  always_comb begin
    busy_d = busy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    op_d   = op_q;
    dest_d = dest_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    val1_d = val1_q;
    val2_d = val2_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        if (!rdy1_q[i] && rs_if.cdb_valid_i && (rs_if.cdb_tag_i == tag1_q[i])) begin
          rdy1_d[i] = 1'b1;
          val1_d[i] = rs_if.cdb_data_i;
        end
        if (!rdy2_q[i] && rs_if.cdb_valid_i && (rs_if.cdb_tag_i == tag2_q[i])) begin
          rdy2_d[i] = 1'b1;
          val2_d[i] = rs_if.cdb_data_i;
        end
        if (issue_fire && (sel_idx == IDX_W'(i))) busy_d[i] = 1'b0;
      end else if (load_fire && (free_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = rs_if.op_i;
        dest_d[i] = rs_if.dest_tag_i;
        tag1_d[i] = rs_if.src1_tag_i;
        tag2_d[i] = rs_if.src2_tag_i;
        // Operand priority: already valid, then same-cycle CDB bypass, else wait on tag.
        if (rs_if.src1_rdy_i) begin
          rdy1_d[i] = 1'b1;
          val1_d[i] = rs_if.src1_val_i;
        end else if (rs_if.cdb_valid_i && (rs_if.cdb_tag_i == rs_if.src1_tag_i)) begin
          rdy1_d[i] = 1'b1;
          val1_d[i] = rs_if.cdb_data_i;
        end else begin
          rdy1_d[i] = 1'b0;
        end
        if (rs_if.src2_rdy_i) begin
          rdy2_d[i] = 1'b1;
          val2_d[i] = rs_if.src2_val_i;
        end else if (rs_if.cdb_valid_i && (rs_if.cdb_tag_i == rs_if.src2_tag_i)) begin
          rdy2_d[i] = 1'b1;
          val2_d[i] = rs_if.cdb_data_i;
        end else begin
          rdy2_d[i] = 1'b0;
        end
      end
    end
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      op_q   <= op_d;
      dest_q <= dest_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
    end
  end

  assign rs_if.res_valid_o   = any_free;
  assign rs_if.issue_valid_o = any_cand;
  assign rs_if.issue_op_o    = any_cand ? op_q[sel_idx]   : '0;
  assign rs_if.issue_dest_o  = any_cand ? dest_q[sel_idx] : '0;
  assign rs_if.issue_a_o     = any_cand ? val1_q[sel_idx] : '0;
  assign rs_if.issue_b_o     = any_cand ? val2_q[sel_idx] : '0;
endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// tb_reservation_station: directed and random checks against a slot-level model
// Revision: 1.0
// ============================================================================
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reservation_station_if #(.DATA_W(32), .TAG_W(3), .OP_W(4)) bus ();

  reservation_station #(.DEPTH(4), .DATA_W(32), .TAG_W(3), .OP_W(4)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .flush_i   (flush),
    .rs_if     (bus.slave)
  );

  typedef struct {
    bit        busy;
    bit [3:0]  op;
    bit [2:0]  dest;
    bit        r1;
    bit [2:0]  t1;
    bit [31:0] v1;
    bit        r2;
    bit [2:0]  t2;
    bit [31:0] v2;
  } ent_t;

  ent_t m [4];

  function automatic int m_free();
    for (int i = 0; i < 4; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < 4; i++) if (m[i].busy && m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    int w;
    w = m_winner();
    chk("res_valid", 32'(bus.res_valid_o), 32'(m_free() >= 0));
    chk("issue_valid", 32'(bus.issue_valid_o), 32'(w >= 0));
    if (w >= 0) begin
      chk("issue_op", 32'(bus.issue_op_o), 32'(m[w].op));
      chk("issue_dest", 32'(bus.issue_dest_o), 32'(m[w].dest));
      chk("issue_a", bus.issue_a_o, m[w].v1);
      chk("issue_b", bus.issue_b_o, m[w].v2);
    end
  endtask

  // What one clock edge does, written in terms of slots and operands.
  task automatic model_edge();
    int   w, f;
    ent_t e;
    w = m_winner();
    f = m_free();
    if (flush) begin
      m_clear();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (m[i].busy && bus.cdb_valid_i) begin
        if (!m[i].r1 && m[i].t1 == bus.cdb_tag_i) begin m[i].r1 = 1; m[i].v1 = bus.cdb_data_i; end
        if (!m[i].r2 && m[i].t2 == bus.cdb_tag_i) begin m[i].r2 = 1; m[i].v2 = bus.cdb_data_i; end
      end
    end
    if (w >= 0 && bus.fu_ready_i) m[w].busy = 0;
    if (bus.res_load_i && f >= 0) begin
      e.busy = 1; e.op = bus.op_i; e.dest = bus.dest_tag_i;
      e.t1 = bus.src1_tag_i; e.t2 = bus.src2_tag_i;
      e.r1 = bus.src1_rdy_i || (bus.cdb_valid_i && bus.cdb_tag_i == bus.src1_tag_i);
      e.v1 = bus.src1_rdy_i ? bus.src1_val_i : bus.cdb_data_i;
      e.r2 = bus.src2_rdy_i || (bus.cdb_valid_i && bus.cdb_tag_i == bus.src2_tag_i);
      e.v2 = bus.src2_rdy_i ? bus.src2_val_i : bus.cdb_data_i;
      m[f] = e;
    end
  endtask

  task automatic step();
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.res_load_i = 0; bus.op_i = 0; bus.dest_tag_i = 0;
    bus.src1_rdy_i = 0; bus.src2_rdy_i = 0; bus.src1_tag_i = 0; bus.src2_tag_i = 0;
    bus.src1_val_i = 0; bus.src2_val_i = 0;
    bus.cdb_valid_i = 0; bus.cdb_tag_i = 0; bus.cdb_data_i = 0;
    flush = 0;
  endtask

  task automatic drv_load(input logic [3:0] op, input logic [2:0] d,
                          input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    bus.res_load_i = 1; bus.op_i = op; bus.dest_tag_i = d;
    bus.src1_rdy_i = r1; bus.src1_tag_i = t1; bus.src1_val_i = v1;
    bus.src2_rdy_i = r2; bus.src2_tag_i = t2; bus.src2_val_i = v2;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] d);
    bus.cdb_valid_i = 1; bus.cdb_tag_i = t; bus.cdb_data_i = d;
  endtask

  initial begin
    idle();
    bus.fu_ready_i = 1;
    m_clear();
    @(negedge clk);
    chk("rst_res_valid", 32'(bus.res_valid_o), 32'd1);
    chk("rst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("rst_op", 32'(bus.issue_op_o), 32'd0);
    chk("rst_dest", 32'(bus.issue_dest_o), 32'd0);
    chk("rst_a", bus.issue_a_o, 32'd0);
    chk("rst_b", bus.issue_b_o, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Ready dispatch
    drv_load(4'd2, 3'd5, 1, 3'd0, 32'd10, 1, 3'd0, 32'd20);
    step(); idle();
    chk("rdy_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("rdy_op", 32'(bus.issue_op_o), 32'd2);
    chk("rdy_dest", 32'(bus.issue_dest_o), 32'd5);
    chk("rdy_a", bus.issue_a_o, 32'd10);
    chk("rdy_b", bus.issue_b_o, 32'd20);
    step();
    chk("rdy_drained", 32'(bus.issue_valid_o), 32'd0);

    // CDB wakeup, with a non-matching broadcast first
    drv_load(4'd3, 3'd1, 0, 3'd3, 32'd0, 1, 3'd0, 32'd7);
    step(); idle();
    cdb(3'd4, 32'hAA);
    step(); idle();
    chk("wake_wrong_tag", 32'(bus.issue_valid_o), 32'd0);
    cdb(3'd3, 32'h55);
    step(); idle();
    chk("wake_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("wake_a", bus.issue_a_o, 32'h55);
    chk("wake_b", bus.issue_b_o, 32'd7);
    step();

    // Load-time bypass
    drv_load(4'd4, 3'd2, 0, 3'd6, 32'd0, 1, 3'd0, 32'd1);
    cdb(3'd6, 32'd9);
    step(); idle();
    chk("byp_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("byp_a", bus.issue_a_o, 32'd9);
    step();

    // Full with backpressure
    bus.fu_ready_i = 0;
    for (int k = 1; k <= 4; k++) begin
      drv_load(4'(k), 3'(k), 1, 3'd0, 32'(100 + k), 1, 3'd0, 32'(200 + k));
      step();
    end
    idle();
    chk("full_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("full_op", 32'(bus.issue_op_o), 32'd1);
    chk("full_a", bus.issue_a_o, 32'd101);
    bus.fu_ready_i = 1;
    step();
    bus.fu_ready_i = 0;
    chk("drain1_res_valid", 32'(bus.res_valid_o), 32'd1);
    chk("drain1_op", 32'(bus.issue_op_o), 32'd2);
    chk("drain1_a", bus.issue_a_o, 32'd102);

    // Flush with three busy entries and a simultaneous load
    drv_load(4'd9, 3'd7, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
    flush = 1;
    step(); idle();
    chk("flush_res_valid", 32'(bus.res_valid_o), 32'd1);
    chk("flush_issue_valid", 32'(bus.issue_valid_o), 32'd0);

    // Async reset with an issue pending
    drv_load(4'd5, 3'd3, 1, 3'd0, 32'd11, 1, 3'd0, 32'd12);
    step(); idle();
    chk("pre_rst_valid", 32'(bus.issue_valid_o), 32'd1);
    #2 rst_n = 0;
    #1;
    m_clear();
    chk("arst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
    chk("arst_res_valid", 32'(bus.res_valid_o), 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      idle();
      flush = ($urandom_range(39) == 0);
      bus.fu_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1) cdb(3'($urandom_range(7)), $urandom);
      if (m_free() >= 0 && $urandom_range(2) != 0)
        drv_load(4'($urandom_range(15)), 3'($urandom_range(7)),
                 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
                 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
